// File: rtl/fir_mem_arbiter.sv
// Round-robin arbiter sharing the single-port FIR sample/result memory between
// the host port and the FIR engine, with burst cap, engine lock and stall counters.
module fir_mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8,
    parameter int STALL_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,
    input  logic              e_req,
    input  logic              e_we,
    input  logic              e_lock,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic [DATA_W-1:0] e_rdata,
    output logic              e_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STALL_W-1:0] h_stall_cnt,
    output logic [STALL_W-1:0] e_stall_cnt
);
    localparam int CNT_W = $clog2(MAX_BURST + 2);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_HOST, S_ENG} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_last_eng, w_last_eng_nxt;
    logic [CNT_W-1:0]   r_burst, w_burst_nxt;
    logic [CNT_W-1:0]   w_cnt_base, w_cnt_inc;
    logic               r_rd_pend, r_rd_tag_eng;
    logic [DATA_W-1:0]  r_h_rdata, r_e_rdata;
    logic [STALL_W-1:0] r_h_stall, r_e_stall;
    logic               w_h_gnt, w_e_gnt, w_xfer, w_other_req;

    always_comb begin
        w_h_gnt        = 1'b0;
        w_e_gnt        = 1'b0;
        w_state_nxt    = r_state;
        w_burst_nxt    = r_burst;
        w_last_eng_nxt = r_last_eng;
        w_cnt_base     = '0;
        w_cnt_inc      = '0;
        w_other_req    = 1'b0;

        // An owner at or past its cap yields to a waiting requester unless the engine holds lock.
        case (r_state)
            S_IDLE: begin
                if (h_req && e_req) begin
                    w_h_gnt = r_last_eng;
                    w_e_gnt = !r_last_eng;
                end else begin
                    w_h_gnt = h_req;
                    w_e_gnt = e_req;
                end
            end
            S_HOST: begin
                if (h_req && !(r_burst >= CAP && e_req)) w_h_gnt = 1'b1;
                else if (e_req)                          w_e_gnt = 1'b1;
            end
            S_ENG: begin
                if (e_req && !(r_burst >= CAP && h_req && !e_lock)) w_e_gnt = 1'b1;
                else if (h_req)                                     w_h_gnt = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            w_h_gnt = 1'b0;
            w_e_gnt = 1'b0;
        end

        if (w_h_gnt || w_e_gnt) begin
            if ((w_h_gnt && r_state == S_HOST) || (w_e_gnt && r_state == S_ENG))
                w_cnt_base = r_burst;
            else if (r_state != S_IDLE)
                w_last_eng_nxt = (r_state == S_ENG);
            w_cnt_inc   = w_cnt_base + CNT_W'(1);
            w_other_req = w_h_gnt ? e_req : h_req;
            w_state_nxt = w_h_gnt ? S_HOST : S_ENG;
            if (w_e_gnt && e_lock) begin
                w_burst_nxt = (w_cnt_inc >= CAP) ? CAP : w_cnt_inc;
            end else if (w_cnt_inc >= CAP) begin
                w_burst_nxt = '0;
                if (w_other_req) begin
                    w_state_nxt    = w_h_gnt ? S_ENG : S_HOST;
                    w_last_eng_nxt = w_e_gnt;
                end
            end else begin
                w_burst_nxt = w_cnt_inc;
            end
        end else begin
            w_state_nxt = S_IDLE;
            w_burst_nxt = '0;
            if (r_state != S_IDLE) w_last_eng_nxt = (r_state == S_ENG);
        end
    end

    assign h_gnt     = w_h_gnt;
    assign e_gnt     = w_e_gnt;
    assign w_xfer    = w_h_gnt | w_e_gnt;
    assign mem_en    = w_xfer;
    assign mem_we    = w_h_gnt ? h_we    : (w_e_gnt ? e_we    : 1'b0);
    assign mem_addr  = w_h_gnt ? h_addr  : (w_e_gnt ? e_addr  : '0);
    assign mem_wdata = w_h_gnt ? h_wdata : (w_e_gnt ? e_wdata : '0);

    assign h_rvalid    = r_rd_pend && !r_rd_tag_eng && !rst;
    assign e_rvalid    = r_rd_pend &&  r_rd_tag_eng && !rst;
    assign h_rdata     = h_rvalid ? mem_rdata : r_h_rdata;
    assign e_rdata     = e_rvalid ? mem_rdata : r_e_rdata;
    assign h_stall_cnt = r_h_stall;
    assign e_stall_cnt = r_e_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_eng   <= 1'b0;
            r_burst      <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_tag_eng <= 1'b0;
            r_h_rdata    <= '0;
            r_e_rdata    <= '0;
            r_h_stall    <= '0;
            r_e_stall    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_eng   <= w_last_eng_nxt;
            r_burst      <= w_burst_nxt;
            r_rd_pend    <= w_xfer && !mem_we;
            r_rd_tag_eng <= w_e_gnt;
            if (h_rvalid) r_h_rdata <= mem_rdata;
            if (e_rvalid) r_e_rdata <= mem_rdata;
            if (h_req && !w_h_gnt && r_h_stall != '1) r_h_stall <= r_h_stall + STALL_W'(1);
            if (e_req && !w_e_gnt && r_e_stall != '1) r_e_stall <= r_e_stall + STALL_W'(1);
        end
    end
endmodule

// File: tb/tb_fir_mem_arbiter.sv
// Bench for fir_mem_arbiter: directed scenarios plus random traffic against a
// tenure-based reference model with a shadow copy of the memory.
module tb_fir_mem_arbiter;
    localparam int MAXB = 4;

    logic clk, rst;
    logic h_req, h_we, e_req, e_we, e_lock;
    logic [9:0] h_addr, e_addr;
    logic [7:0] h_wdata, e_wdata;

    logic h_gnt, h_rvalid, e_gnt, e_rvalid, mem_en, mem_we;
    logic [7:0] h_rdata, e_rdata, mem_wdata;
    logic [9:0] mem_addr;
    logic [15:0] h_stall_cnt, e_stall_cnt;
    bit   [7:0] mem_rdata;

    logic b_h_gnt, b_h_rvalid, b_e_gnt, b_e_rvalid, b_mem_en, b_mem_we;
    logic [7:0] b_h_rdata, b_e_rdata, b_mem_wdata;
    logic [9:0] b_mem_addr;
    logic [3:0] b_h_stall, b_e_stall;

    int checks = 0;
    int errors = 0;

    fir_mem_arbiter #(.ADDR_W(10), .DATA_W(8), .MAX_BURST(MAXB), .STALL_W(16)) dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rdata(e_rdata), .e_rvalid(e_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .h_stall_cnt(h_stall_cnt), .e_stall_cnt(e_stall_cnt));

    fir_mem_arbiter #(.ADDR_W(10), .DATA_W(8), .MAX_BURST(MAXB), .STALL_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(b_h_gnt), .h_rdata(b_h_rdata), .h_rvalid(b_h_rvalid),
        .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(b_e_gnt), .e_rdata(b_e_rdata), .e_rvalid(b_e_rvalid),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .h_stall_cnt(b_h_stall), .e_stall_cnt(b_e_stall));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port memory, write-first on the following cycle
    bit [7:0] hmem [1024];
    always @(posedge clk) begin
        if (mem_en && mem_we) hmem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= hmem[mem_addr];
    end

    // Reference model: owner tenure, transfers in tenure, previous owner (1=host, 2=engine)
    int m_cur, m_run, m_last, m_g, m_ptag, m_hst, m_est;
    bit m_pend;
    bit [7:0] m_pdata, m_hlast, m_elast;
    bit [7:0] shadow [1024];
    bit ex_hg, ex_eg, ex_en, ex_we, ex_hv, ex_ev;
    bit [9:0] ex_addr;
    bit [7:0] ex_wd, ex_hd, ex_ed;

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function void model_reset();
        m_cur = 0; m_run = 0; m_last = 1; m_pend = 0; m_ptag = 0;
        m_pdata = 0; m_hlast = 0; m_elast = 0; m_hst = 0; m_est = 0;
    endfunction

    function void model_eval();
        int g;
        bit oreq, xreq, locked;
        g = 0;
        if (!rst) begin
            if (m_cur == 0) begin
                if (h_req && e_req) g = (m_last == 1) ? 2 : 1;
                else if (h_req)     g = 1;
                else if (e_req)     g = 2;
            end else begin
                oreq   = (m_cur == 1) ? h_req : e_req;
                xreq   = (m_cur == 1) ? e_req : h_req;
                locked = (m_cur == 2) && e_lock;
                if (oreq && (m_run < MAXB || !xreq || locked)) g = m_cur;
                else if (xreq)                                 g = 3 - m_cur;
            end
        end
        m_g     = g;
        ex_hg   = (g == 1);
        ex_eg   = (g == 2);
        ex_en   = (g != 0);
        ex_we   = (g == 1) ? h_we    : (g == 2) ? e_we    : 1'b0;
        ex_addr = (g == 1) ? h_addr  : (g == 2) ? e_addr  : 10'd0;
        ex_wd   = (g == 1) ? h_wdata : (g == 2) ? e_wdata : 8'd0;
        ex_hv   = !rst && m_pend && m_ptag == 1;
        ex_ev   = !rst && m_pend && m_ptag == 2;
        ex_hd   = ex_hv ? m_pdata : m_hlast;
        ex_ed   = ex_ev ? m_pdata : m_elast;
    endfunction

    function void model_commit();
        bit oth;
        if (rst) begin
            model_reset();
            return;
        end
        if (ex_hv) m_hlast = m_pdata;
        if (ex_ev) m_elast = m_pdata;
        if (h_req && !ex_hg && m_hst < 65535) m_hst++;
        if (e_req && !ex_eg && m_est < 65535) m_est++;
        m_pend = ex_en && !ex_we;
        m_ptag = m_g;
        if (m_pend) m_pdata = shadow[ex_addr];
        if (ex_en && ex_we) shadow[ex_addr] = ex_wd;
        if (m_g != 0) begin
            if (m_g != m_cur) begin
                if (m_cur != 0) m_last = m_cur;
                m_cur = m_g;
                m_run = 0;
            end
            m_run++;
            oth = (m_g == 1) ? e_req : h_req;
            if (!(m_g == 2 && e_lock) && m_run >= MAXB) begin
                m_run = 0;
                if (oth) begin
                    m_last = m_g;
                    m_cur  = 3 - m_g;
                end
            end
        end else begin
            if (m_cur != 0) m_last = m_cur;
            m_cur = 0;
            m_run = 0;
        end
    endfunction

    task automatic drive(input logic r, input logic hq, input logic hw, input logic [9:0] ha,
                         input logic [7:0] hd, input logic eq, input logic ew, input logic el,
                         input logic [9:0] ea, input logic [7:0] ed);
        rst = r; h_req = hq; h_we = hw; h_addr = ha; h_wdata = hd;
        e_req = eq; e_we = ew; e_lock = el; e_addr = ea; e_wdata = ed;
        @(negedge clk);
        model_eval();
    endtask

    task automatic commit();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        commit();
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        commit();
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 10'd3, 8'h11, 1, 0, 0, 10'd4, 8'h22);
        checks++;
        if ({h_gnt, e_gnt, mem_en, h_rvalid, e_rvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_gnt got %b want 00000", {h_gnt, e_gnt, mem_en, h_rvalid, e_rvalid});
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({h_gnt, e_gnt, h_rvalid, e_rvalid, mem_en, mem_we} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl got %b want 000000", {h_gnt, e_gnt, h_rvalid, e_rvalid, mem_en, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, h_rdata, e_rdata} !== 34'd0 || h_stall_cnt !== 16'd0 || e_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_data got addr %h wd %h hrd %h erd %h hst %0d est %0d want all 0",
                               mem_addr, mem_wdata, h_rdata, e_rdata, h_stall_cnt, e_stall_cnt);
        end
        commit();
    endtask

    task automatic test_host_only();
        drive(0, 1, 1, 10'd5, 8'h28, 0, 0, 0, 0, 0);
        checks++;
        if (h_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd5 || mem_wdata !== 8'h28) begin
            errors++; $display("FAIL host_write got gnt %b en %b we %b addr %0d wd %h want 1 1 1 5 28",
                               h_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        commit();
        drive(0, 1, 0, 10'd5, 8'h00, 0, 0, 0, 0, 0);
        checks++;
        if (h_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || e_gnt !== 1'b0) begin
            errors++; $display("FAIL host_read_gnt got hgnt %b en %b we %b egnt %b want 1 1 0 0", h_gnt, mem_en, mem_we, e_gnt);
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (h_rvalid !== 1'b1 || h_rdata !== 8'h28 || e_rvalid !== 1'b0) begin
            errors++; $display("FAIL host_readback got rv %b rd %h erv %b want 1 28 0", h_rvalid, h_rdata, e_rvalid);
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (h_rvalid !== 1'b0 || h_rdata !== 8'h28) begin
            errors++; $display("FAIL host_hold got rv %b rd %h want 0 28", h_rvalid, h_rdata);
        end
        commit();
    endtask

    task automatic test_tie();
        do_reset();
        drive(0, 1, 0, 10'd1, 0, 1, 0, 0, 10'd2, 0);
        checks++;
        if (e_gnt !== 1'b1 || h_gnt !== 1'b0) begin
            errors++; $display("FAIL tie_first got egnt %b hgnt %b want 1 0", e_gnt, h_gnt);
        end
        commit();
        drive(0, 1, 0, 10'd1, 0, 1, 0, 0, 10'd2, 0);
        checks++;
        if (h_stall_cnt !== 16'd1 || e_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL tie_stall got h %0d e %0d want 1 0", h_stall_cnt, e_stall_cnt);
        end
        commit();
        idle_cycle();
    endtask

    task automatic test_burst_cap();
        bit want_e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 1'($urandom_range(1)), 10'($urandom_range(63)), 8'($urandom),
                  1, 1'($urandom_range(1)), 0, 10'($urandom_range(63)), 8'($urandom));
            want_e = ((i / MAXB) % 2) == 0;
            checks++;
            if (e_gnt !== want_e || h_gnt !== !want_e) begin
                errors++; $display("FAIL burst_pattern cycle %0d got egnt %b hgnt %b want %b %b", i, e_gnt, h_gnt, want_e, !want_e);
            end
            checks++;
            if (e_gnt !== ex_eg || h_gnt !== ex_hg || mem_addr !== ex_addr) begin
                errors++; $display("FAIL burst_model cycle %0d got e %b h %b addr %0d want %b %b %0d",
                                   i, e_gnt, h_gnt, mem_addr, ex_eg, ex_hg, ex_addr);
            end
            commit();
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_lock();
        int ecount;
        ecount = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 10'd7, 0, 1, 1'($urandom_range(1)), 1, 10'($urandom_range(31)), 8'($urandom));
            if (e_gnt === 1'b1 && h_gnt === 1'b0) ecount++;
            commit();
        end
        checks++;
        if (ecount != 20) begin
            errors++; $display("FAIL lock_eng_xfers got %0d want 20", ecount);
        end
        drive(0, 1, 0, 10'd7, 0, 1, 0, 0, 10'd8, 0);
        checks++;
        if (h_gnt !== 1'b1 || e_gnt !== 1'b0) begin
            errors++; $display("FAIL lock_release got hgnt %b egnt %b want 1 0", h_gnt, e_gnt);
        end
        checks++;
        if (h_stall_cnt !== 16'd20) begin
            errors++; $display("FAIL lock_stall got %0d want 20", h_stall_cnt);
        end
        checks++;
        if (b_h_stall !== 4'd15) begin
            errors++; $display("FAIL stall_saturate got %0d want 15", b_h_stall);
        end
        commit();
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_interleave();
        logic [7:0] a, b;
        a = 8'($urandom);
        b = a ^ 8'h5A;
        do_reset();
        drive(0, 1, 1, 10'd32, a, 0, 0, 0, 0, 0); commit();
        drive(0, 1, 1, 10'd0,  b, 0, 0, 0, 0, 0); commit();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 10'd32, 0);
        checks++;
        if (e_gnt !== 1'b1 || h_gnt !== 1'b0) begin
            errors++; $display("FAIL ilv_eng_gnt got egnt %b hgnt %b want 1 0", e_gnt, h_gnt);
        end
        commit();
        drive(0, 1, 0, 10'd0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (h_gnt !== 1'b1 || e_rvalid !== 1'b1 || e_rdata !== a || h_rvalid !== 1'b0) begin
            errors++; $display("FAIL ilv_eng_data got hgnt %b erv %b erd %h hrv %b want 1 1 %h 0", h_gnt, e_rvalid, e_rdata, h_rvalid, a);
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (h_rvalid !== 1'b1 || h_rdata !== b || e_rvalid !== 1'b0 || e_rdata !== a) begin
            errors++; $display("FAIL ilv_host_data got hrv %b hrd %h erv %b erd %h want 1 %h 0 %h", h_rvalid, h_rdata, e_rvalid, e_rdata, b, a);
        end
        commit();
    endtask

    task automatic test_rst_mid();
        drive(0, 1, 0, 10'd32, 0, 1, 0, 0, 10'd0, 0);
        commit();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (h_rvalid !== 1'b0 || e_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_drop_rvalid got hrv %b erv %b want 0 0", h_rvalid, e_rvalid);
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({h_gnt, e_gnt, h_rvalid, e_rvalid, mem_en, mem_we, mem_addr, mem_wdata, h_rdata, e_rdata} !== 40'd0 ||
            h_stall_cnt !== 16'd0 || e_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid_outputs got rv %b%b rd %h %h hst %0d est %0d want all 0",
                               h_rvalid, e_rvalid, h_rdata, e_rdata, h_stall_cnt, e_stall_cnt);
        end
        commit();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(59) == 0), ($urandom_range(2) != 0), 1'($urandom_range(1)),
                  10'($urandom_range(15)), 8'($urandom), ($urandom_range(2) != 0), 1'($urandom_range(1)),
                  ($urandom_range(4) == 0), 10'($urandom_range(15)), 8'($urandom));
            checks++;
            if (h_gnt !== ex_hg || e_gnt !== ex_eg || (h_gnt && e_gnt)) begin
                errors++; $display("FAIL rnd_gnt cycle %0d got h %b e %b want %b %b", i, h_gnt, e_gnt, ex_hg, ex_eg);
            end
            checks++;
            if (mem_en !== ex_en || mem_we !== ex_we || mem_addr !== ex_addr || mem_wdata !== ex_wd) begin
                errors++; $display("FAIL rnd_mux cycle %0d got %b %b %0d %h want %b %b %0d %h",
                                   i, mem_en, mem_we, mem_addr, mem_wdata, ex_en, ex_we, ex_addr, ex_wd);
            end
            checks++;
            if (h_rvalid !== ex_hv || e_rvalid !== ex_ev || h_rdata !== ex_hd || e_rdata !== ex_ed) begin
                errors++; $display("FAIL rnd_read cycle %0d got %b %b %h %h want %b %b %h %h",
                                   i, h_rvalid, e_rvalid, h_rdata, e_rdata, ex_hv, ex_ev, ex_hd, ex_ed);
            end
            checks++;
            if (h_stall_cnt !== 16'(m_hst) || e_stall_cnt !== 16'(m_est) ||
                b_h_stall !== 4'(sat15(m_hst)) || b_e_stall !== 4'(sat15(m_est))) begin
                errors++; $display("FAIL rnd_stall cycle %0d got %0d %0d %0d %0d want %0d %0d %0d %0d",
                                   i, h_stall_cnt, e_stall_cnt, b_h_stall, b_e_stall, m_hst, m_est, sat15(m_hst), sat15(m_est));
            end
            commit();
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1; h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
        e_req = 0; e_we = 0; e_lock = 0; e_addr = 0; e_wdata = 0;
        test_reset();
        test_host_only();
        test_tie();
        test_burst_cap();
        test_lock();
        test_interleave();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
